// File: rtl/lsu_mem_port.sv
// Load/store memory port: lane-aligns stores, runs a req/ack handshake with optional
// timeout, and returns extended or LWL/LWR-merged load data with a one-cycle done pulse.
module lsu_mem_port #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_is_store,
  input  logic [2:0]  i_sl_ctrl,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [31:0] o_rdata,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [3:0]  o_mem_be,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);

  localparam logic [2:0] SlWord  = 3'b000;
  localparam logic [2:0] SlHalf  = 3'b001;
  localparam logic [2:0] SlByte  = 3'b010;
  localparam logic [2:0] SlHalfU = 3'b011;
  localparam logic [2:0] SlByteU = 3'b100;
  localparam logic [2:0] SlWordL = 3'b101;
  localparam logic [2:0] SlWordR = 3'b110;

  localparam int unsigned CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CW-1:0] CntLast = CW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_t;

  state_t      r_state;
  logic [CW-1:0] r_cnt;
  logic        r_store;
  logic [2:0]  r_sl;
  logic [1:0]  r_n;
  logic [31:0] r_rt;
  logic        r_busy, r_done, r_err, r_mem_req, r_mem_we;
  logic [31:0] r_rdata, r_mem_addr, r_mem_wdata;
  logic [3:0]  r_mem_be;

  logic        w_bad;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [4:0]  w_sh, w_shl;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;

  // Request-side decode from the live inputs, used only on the accepting edge.
  always_comb begin
    w_sh    = {i_addr[1:0], 3'b000};
    w_shl   = {~i_addr[1:0], 3'b000};
    w_be    = 4'b1111;
    w_wdata = i_wdata;
    w_bad   = 1'b0;
    unique case (i_sl_ctrl)
      SlWord: w_bad = (i_addr[1:0] != 2'b00);
      SlHalf, SlHalfU: begin
        w_bad   = i_addr[0];
        w_be    = 4'b0011 << i_addr[1:0];
        w_wdata = {2{i_wdata[15:0]}};
      end
      SlByte, SlByteU: begin
        w_be    = 4'b0001 << i_addr[1:0];
        w_wdata = {4{i_wdata[7:0]}};
      end
      SlWordL: begin
        w_be    = 4'b1111 >> ~i_addr[1:0];
        w_wdata = i_wdata >> w_shl;
      end
      SlWordR: begin
        w_be    = 4'b1111 << i_addr[1:0];
        w_wdata = i_wdata << w_sh;
      end
      default: w_bad = 1'b1;
    endcase
    if (!i_is_store) begin
      w_be    = 4'b1111;
      w_wdata = 32'h0;
    end
  end

  // Load-side extraction; r_rt holds the old rt value for the unaligned merges.
  always_comb begin
    w_byte = 8'(i_mem_rdata >> {r_n, 3'b000});
    w_half = r_n[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    w_load = i_mem_rdata;
    case (r_sl)
      SlHalf:  w_load = {{16{w_half[15]}}, w_half};
      SlHalfU: w_load = {16'h0, w_half};
      SlByte:  w_load = {{24{w_byte[7]}}, w_byte};
      SlByteU: w_load = {24'h0, w_byte};
      SlWordL: begin
        case (r_n)
          2'd0:    w_load = {i_mem_rdata[7:0], r_rt[23:0]};
          2'd1:    w_load = {i_mem_rdata[15:0], r_rt[15:0]};
          2'd2:    w_load = {i_mem_rdata[23:0], r_rt[7:0]};
          default: w_load = i_mem_rdata;
        endcase
      end
      SlWordR: begin
        case (r_n)
          2'd0:    w_load = i_mem_rdata;
          2'd1:    w_load = {r_rt[31:24], i_mem_rdata[31:8]};
          2'd2:    w_load = {r_rt[31:16], i_mem_rdata[31:16]};
          default: w_load = {r_rt[31:8], i_mem_rdata[31:24]};
        endcase
      end
      default: w_load = i_mem_rdata;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_store     <= 1'b0;
      r_sl        <= 3'b000;
      r_n         <= 2'b00;
      r_rt        <= 32'h0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= 32'h0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= 4'b0000;
      r_mem_addr  <= 32'h0;
      r_mem_wdata <= 32'h0;
    end else begin
      case (r_state)
        StIdle: begin
          if (i_start) begin
            r_store <= i_is_store;
            r_sl    <= i_sl_ctrl;
            r_n     <= i_addr[1:0];
            r_rt    <= i_wdata;
            r_busy  <= 1'b1;
            if (w_bad) begin
              r_state <= StResp;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else begin
              r_state     <= StReq;
              r_cnt       <= '0;
              r_mem_req   <= 1'b1;
              r_mem_we    <= i_is_store;
              r_mem_be    <= w_be;
              r_mem_addr  <= {i_addr[31:2], 2'b00};
              r_mem_wdata <= w_wdata;
            end
          end
        end
        StReq: begin
          if (i_mem_ack) begin
            r_state   <= StResp;
            r_done    <= 1'b1;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            if (!r_store) r_rdata <= w_load;
          end else if (ACK_TIMEOUT != 0 && r_cnt == CntLast) begin
            r_state   <= StResp;
            r_done    <= 1'b1;
            r_err     <= 1'b1;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StResp: begin
          r_state <= StIdle;
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_rdata     = r_rdata;
  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_be    = r_mem_be;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;

endmodule
